// File: rtl/signal_debouncer.sv
// signal_debouncer: synchronises an asynchronous raw level into clk and
// debounces it so only levels held for STABLE_CYCLES enabled samples pass.
//
// Ports:
//   clk         in   posedge clock for every flop
//   rst         in   asynchronous active-low reset
//   raw_in      in   asynchronous raw level
//   enable      in   1 = qualify, 0 = freeze debounce state
//   signal_out  out  debounced level (registered)
//   busy        out  high while a candidate level is being qualified
//   glitch_cnt  out  saturating count of rejected candidates
//                    (present only when DEBOUNCE_GLITCH_CNT_EN is defined)
//
// Parameters:
//   SYNC_STAGES    synchroniser depth (>= 2)
//   STABLE_CYCLES  enabled samples a new level must persist (>= 1)
//   GLITCH_W       glitch counter width
//
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN

module signal_debouncer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                raw_in,
  input  logic                enable,
  output logic                signal_out,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
`else
  output logic                busy
`endif
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || GLITCH_W < 1)
  begin : g_param_check
    $error("signal_debouncer: illegal parameter value");
  end

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   busy_q, busy_d;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
`endif

  // Synchroniser keeps shifting even when debouncing is frozen,
  // so a freeze never leaves a stale sample in the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    glitch_d = glitch_q;
`endif
    if (enable) begin
      unique case (state_q)
        ST_STABLE: begin
          if (sync_s != out_q) begin
            // A single-sample qualification completes immediately.
            if (STABLE_CYCLES == 1) begin
              out_d = sync_s;
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_QUALIFY;
            end
          end
        end
        ST_QUALIFY: begin
          if (sync_s == out_q) begin
            // Candidate fell back before qualifying: reject it.
            cnt_d   = '0;
            state_d = ST_STABLE;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            if (glitch_q != {GLITCH_W{1'b1}}) begin
              glitch_d = glitch_q + GLITCH_W'(1);
            end
`endif
          end else if (cnt_q == CNT_LAST) begin
            out_d   = sync_s;
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end
    busy_d = (state_d == ST_QUALIFY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_q <= glitch_d;
`endif
    end
  end

  assign signal_out = out_q;
  assign busy       = busy_q;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt = glitch_q;
`endif

endmodule
